// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad passcode entry controller.
package lock_pkg;
    typedef enum logic [1:0] {ENTRY, SUBMIT, CHECK, LOCKOUT} state_e;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction
endpackage

// File: rtl/passcode_entry_btn_edge.sv
// Registers a debounced button level and flags its rising edge for one cycle.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);
    logic level_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= level_i;
            prev_q  <= level_q;
        end
    end

    assign rise_o = level_q & ~prev_q;
endmodule

// File: rtl/passcode_entry.sv
// Keypad digit-entry FSM: builds a 4-digit BCD code, strobes it to the
// password manager, counts failed checks and enforces a timed lockout.
module passcode_entry
    import lock_pkg::*;
#(
    parameter int          MAX_FAILS      = 3,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd125_000_000,
    parameter logic [31:0] IDLE_CYCLES    = 32'd1_250_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           btn_up,
    input  logic                           btn_next,
    input  logic                           btn_enter,
    input  logic                           match,
    input  logic                           change_mode,
    output logic [3:0]                     bcd0,
    output logic [3:0]                     bcd1,
    output logic [3:0]                     bcd2,
    output logic [3:0]                     bcd3,
    output logic                           btn_confirm_fullpass,
    output logic [1:0]                     cursor,
    output logic                           locked,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);
    localparam int             FW         = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0]  FAIL_LIMIT = FW'(MAX_FAILS);

    logic up_e, next_e, enter_e;

    btn_edge u_up    (.clk(clk), .rst_n(rst_n), .level_i(btn_up),    .rise_o(up_e));
    btn_edge u_next  (.clk(clk), .rst_n(rst_n), .level_i(btn_next),  .rise_o(next_e));
    btn_edge u_enter (.clk(clk), .rst_n(rst_n), .level_i(btn_enter), .rise_o(enter_e));

    state_e                          state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]      digit_q, digit_d;
    logic [1:0]                      cursor_q, cursor_d;
    logic [FW-1:0]                   fail_q, fail_d;
    logic [31:0]                     cnt_q, cnt_d;
    logic                            chg_q, chg_d;
    logic                            confirm_q, locked_q;

    // cnt_q is the idle timer in ENTRY and the lockout timer in LOCKOUT.
    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cursor_d = cursor_q;
        fail_d   = fail_q;
        cnt_d    = cnt_q;
        chg_d    = chg_q;
        case (state_q)
            ENTRY: begin
                if (up_e || next_e || enter_e) begin
                    cnt_d = 32'd0;
                end else if (cnt_q == IDLE_CYCLES - 32'd1) begin
                    digit_d  = '0;
                    cursor_d = 2'd0;
                    cnt_d    = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (enter_e) begin
                    state_d = SUBMIT;
                    chg_d   = change_mode;
                end else if (next_e) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (up_e) begin
                    digit_d[cursor_q] = digit_inc(digit_q[cursor_q]);
                end
            end
            SUBMIT: state_d = CHECK;
            CHECK: begin
                digit_d  = '0;
                cursor_d = 2'd0;
                cnt_d    = 32'd0;
                state_d  = ENTRY;
                // In change mode match reflects the old password, so skip accounting.
                if (!chg_q) begin
                    if (match) begin
                        fail_d = '0;
                    end else begin
                        fail_d = fail_q + FW'(1);
                        if (fail_d == FAIL_LIMIT) state_d = LOCKOUT;
                    end
                end
            end
            LOCKOUT: begin
                if (cnt_q == LOCKOUT_CYCLES - 32'd1) begin
                    cnt_d   = 32'd0;
                    fail_d  = '0;
                    state_d = ENTRY;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ENTRY;
            digit_q   <= '0;
            cursor_q  <= 2'd0;
            fail_q    <= '0;
            cnt_q     <= 32'd0;
            chg_q     <= 1'b0;
            confirm_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            cursor_q  <= cursor_d;
            fail_q    <= fail_d;
            cnt_q     <= cnt_d;
            chg_q     <= chg_d;
            confirm_q <= (state_d == SUBMIT);
            locked_q  <= (state_d == LOCKOUT);
        end
    end

    assign bcd0                 = digit_q[0];
    assign bcd1                 = digit_q[1];
    assign bcd2                 = digit_q[2];
    assign bcd3                 = digit_q[3];
    assign cursor               = cursor_q;
    assign fail_count           = fail_q;
    assign btn_confirm_fullpass = confirm_q;
    assign locked               = locked_q;
endmodule
